// File: rtl/tx_link_framer.sv
// Packet framer ahead of the 8b/10b encoder: idle commas, SOF/EOF delimiters, underrun fill, comma re-insertion, oversize abort.
// Latency: the character chosen on a tx_ce cycle is registered and appears with tx_en one clk later.
// Backpressure: s_ready is combinational and only high on tx_ce slots in DATA with no comma or abort pending; TX_LINK_FRAMER_CRC_EN appends CRC-16.
module tx_link_framer #(
    parameter int MAX_PAYLOAD    = 256,
    parameter int COMMA_INTERVAL = 1024,
    parameter int MIN_IDLE       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_ce,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] tx_data,
    output logic       tx_k,
    output logic       tx_en,
    output logic       err_oversize
);

    localparam logic [7:0] K_COMMA = 8'hBC;
    localparam logic [7:0] K_SOF   = 8'hFB;
    localparam logic [7:0] K_EOF   = 8'hFD;
    localparam logic [7:0] K_FILL  = 8'hF7;
    localparam logic [7:0] K_ABORT = 8'hFE;

    localparam logic [15:0] COMMA_LIM = 16'(COMMA_INTERVAL - 1);
    localparam logic [15:0] PAY_LIM   = 16'(MAX_PAYLOAD);
    localparam logic [7:0]  IDLE_LIM  = 8'(MIN_IDLE);

`ifdef TX_LINK_FRAMER_CRC_EN
    typedef enum logic [2:0] {ST_IDLE, ST_SOF, ST_DATA, ST_EOF, ST_CRC_H, ST_CRC_L} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_SOF, ST_DATA, ST_EOF} state_t;
`endif

    state_t      state, state_nxt;
    logic [7:0]  idle_cnt, idle_nxt, idle_inc;
    logic [15:0] comma_cnt, comma_nxt;
    logic [15:0] pay_cnt, pay_nxt;
    logic [7:0]  chr;
    logic        chr_k;
    logic        abort;
    logic        comma_due;
    logic        oversize_due;

`ifdef TX_LINK_FRAMER_CRC_EN
    logic [15:0] crc, crc_nxt;

    // CRC-16/CCITT, MSB-first: feed data bits one at a time into the LFSR
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction
`endif

    // SOF/EOF/CRC slots can carry comma_cnt past the limit, so compare with >=
    assign comma_due    = (comma_cnt >= COMMA_LIM);
    assign oversize_due = (pay_cnt == PAY_LIM);
    assign s_ready      = tx_ce && (state == ST_DATA) && !comma_due && !oversize_due;
    assign idle_inc     = (idle_cnt == 8'hFF) ? idle_cnt : idle_cnt + 8'd1;

    always_comb begin
        state_nxt = state;
        idle_nxt  = idle_cnt;
        pay_nxt   = pay_cnt;
        chr       = K_COMMA;
        chr_k     = 1'b1;
        abort     = 1'b0;
`ifdef TX_LINK_FRAMER_CRC_EN
        crc_nxt   = crc;
`endif
        case (state)
            ST_IDLE: begin
                idle_nxt = idle_inc;
                if (s_valid && (idle_inc >= IDLE_LIM)) state_nxt = ST_SOF;
            end
            ST_SOF: begin
                chr       = K_SOF;
                pay_nxt   = 16'd0;
`ifdef TX_LINK_FRAMER_CRC_EN
                crc_nxt   = 16'hFFFF;
`endif
                state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (comma_due) begin
                    chr = K_COMMA;
                end else if (oversize_due) begin
                    chr       = K_ABORT;
                    abort     = 1'b1;
                    state_nxt = ST_EOF;
                end else if (s_valid) begin
                    chr     = s_data;
                    chr_k   = 1'b0;
                    pay_nxt = pay_cnt + 16'd1;
`ifdef TX_LINK_FRAMER_CRC_EN
                    crc_nxt = crc16_byte(crc, s_data);
                    if (s_last) state_nxt = ST_CRC_H;
`else
                    if (s_last) state_nxt = ST_EOF;
`endif
                end else begin
                    chr = K_FILL;
                end
            end
`ifdef TX_LINK_FRAMER_CRC_EN
            ST_CRC_H: begin
                if (!comma_due) begin
                    chr       = crc[15:8];
                    chr_k     = 1'b0;
                    state_nxt = ST_CRC_L;
                end
            end
            ST_CRC_L: begin
                if (!comma_due) begin
                    chr       = crc[7:0];
                    chr_k     = 1'b0;
                    state_nxt = ST_EOF;
                end
            end
`endif
            ST_EOF: begin
                chr       = K_EOF;
                idle_nxt  = 8'd0;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // only a K28.5 resets the run length; a 0xBC data byte does not
        if (chr_k && (chr == K_COMMA)) comma_nxt = 16'd0;
        else if (comma_cnt == 16'hFFFF) comma_nxt = comma_cnt;
        else comma_nxt = comma_cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            idle_cnt     <= 8'd0;
            comma_cnt    <= 16'd0;
            pay_cnt      <= 16'd0;
            tx_data      <= K_COMMA;
            tx_k         <= 1'b1;
            tx_en        <= 1'b0;
            err_oversize <= 1'b0;
`ifdef TX_LINK_FRAMER_CRC_EN
            crc          <= 16'hFFFF;
`endif
        end else begin
            tx_en        <= tx_ce;
            err_oversize <= 1'b0;
            if (tx_ce) begin
                state        <= state_nxt;
                idle_cnt     <= idle_nxt;
                comma_cnt    <= comma_nxt;
                pay_cnt      <= pay_nxt;
                tx_data      <= chr;
                tx_k         <= chr_k;
                err_oversize <= abort;
`ifdef TX_LINK_FRAMER_CRC_EN
                crc          <= crc_nxt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_tx_link_framer.sv
// Scoreboard bench for tx_link_framer: three instances (default, COMMA_INTERVAL=4, MAX_PAYLOAD=4).
// Expected characters are queued by the stimulus; a negedge monitor pops and compares on each tx_en.
module tb_tx_link_framer;

    typedef struct packed {
        logic [7:0] dat;
        logic       k;
        logic       err;
        logic       skip;   // leading idle commas may precede this entry
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_ce;
    logic [7:0] s_data [3];
    logic [2:0] s_valid;
    logic [2:0] s_last;
    logic [2:0] s_ready;
    logic [7:0] tx_data [3];
    logic [2:0] tx_k;
    logic [2:0] tx_en;
    logic [2:0] err_ov;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         sel = 0;
    bit         mon_on = 1'b0;
    bit         ce_run = 1'b0;
    bit         ce_alt = 1'b0;
    exp_t       exp_q[$];
    logic [7:0] pkt[$];

    always #5 clk = ~clk;

    tx_link_framer #(.MAX_PAYLOAD(256), .COMMA_INTERVAL(1024), .MIN_IDLE(2)) dut0 (
        .clk(clk), .rst(rst), .tx_ce(tx_ce), .s_data(s_data[0]), .s_valid(s_valid[0]),
        .s_last(s_last[0]), .s_ready(s_ready[0]), .tx_data(tx_data[0]), .tx_k(tx_k[0]),
        .tx_en(tx_en[0]), .err_oversize(err_ov[0]));

    tx_link_framer #(.MAX_PAYLOAD(256), .COMMA_INTERVAL(4), .MIN_IDLE(2)) dut1 (
        .clk(clk), .rst(rst), .tx_ce(tx_ce), .s_data(s_data[1]), .s_valid(s_valid[1]),
        .s_last(s_last[1]), .s_ready(s_ready[1]), .tx_data(tx_data[1]), .tx_k(tx_k[1]),
        .tx_en(tx_en[1]), .err_oversize(err_ov[1]));

    tx_link_framer #(.MAX_PAYLOAD(4), .COMMA_INTERVAL(1024), .MIN_IDLE(2)) dut2 (
        .clk(clk), .rst(rst), .tx_ce(tx_ce), .s_data(s_data[2]), .s_valid(s_valid[2]),
        .s_last(s_last[2]), .s_ready(s_ready[2]), .tx_data(tx_data[2]), .tx_k(tx_k[2]),
        .tx_en(tx_en[2]), .err_oversize(err_ov[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic k, input logic e, input logic sk);
        exp_t x;
        x.dat = d; x.k = k; x.err = e; x.skip = sk;
        exp_q.push_back(x);
    endtask

    task automatic push_pkt_bytes();
        foreach (pkt[i]) push(pkt[i], 1'b0, 1'b0, 1'b0);
    endtask

`ifdef TX_LINK_FRAMER_CRC_EN
    // byte-wise CRC-16/CCITT-FALSE reference over a slice of pkt
    function automatic logic [15:0] crc_ref(input int first, input int cnt);
        logic [15:0] c = 16'hFFFF;
        for (int i = first; i < first + cnt; i++) begin
            c = c ^ {pkt[i], 8'h00};
            for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction
`endif

    // character-slot strobe: continuous, or every other cycle when ce_alt is set
    initial begin
        tx_ce = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!ce_run) tx_ce = 1'b0;
            else if (ce_alt) tx_ce = ~tx_ce;
            else tx_ce = 1'b1;
        end
    end

    // monitor: every character strobed by the selected DUT is checked
    always @(negedge clk) begin
        if (mon_on && tx_en[sel]) begin
            exp_t e;
            logic [9:0] obs;
            obs = {tx_data[sel], tx_k[sel], err_ov[sel]};
            if (exp_q.size() == 0) begin
                check("idle_char", 32'(obs), 32'({8'hBC, 1'b1, 1'b0}));
            end else if (exp_q[0].skip && obs == {8'hBC, 1'b1, 1'b0}) begin
                n_cmp = n_cmp;
            end else begin
                e = exp_q.pop_front();
                check("stream_char", 32'(obs), 32'({e.dat, e.k, e.err}));
            end
        end
    end

    // drive pkt into DUT d; gap_len idle-valid slots after byte index gap_after
    task automatic send(input int d, input int gap_after, input int gap_len, input bit with_last);
        bit acc;
        int cyc;
        for (int i = 0; i < pkt.size(); i++) begin
            s_data[d]  = pkt[i];
            s_valid[d] = 1'b1;
            s_last[d]  = with_last && (i == pkt.size() - 1);
            acc = 1'b0;
            cyc = 0;
            while (!acc && cyc < 200) begin
                @(negedge clk);
                acc = s_ready[d] && s_valid[d];
                @(posedge clk);
                #1;
                cyc++;
            end
            if (!acc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_timeout: dut %0d byte %0d never accepted, expected acceptance within 200 cycles", d, i);
            end
            if (i == gap_after) begin
                s_valid[d] = 1'b0;
                s_last[d]  = 1'b1;   // must be ignored while s_valid is low
                s_data[d]  = 8'h5A;
                repeat (gap_len) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        s_valid[d] = 1'b0;
        s_last[d]  = 1'b0;
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        repeat (6) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef TX_LINK_FRAMER_CRC_EN
        logic [15:0] c;
`endif
        rst     = 1'b1;
        s_valid = '0;
        s_last  = '0;
        for (int i = 0; i < 3; i++) s_data[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_tx_data", 32'(tx_data[i]), 32'hBC);
            check("rst_tx_k", 32'(tx_k[i]), 32'd1);
            check("rst_tx_en", 32'(tx_en[i]), 32'd0);
            check("rst_err", 32'(err_ov[i]), 32'd0);
        end
        ce_run = 1'b1;
        @(negedge clk);
        check("tx_en_first_cycle", 32'(tx_en[0]), 32'd0);
        check("s_ready_idle", 32'(s_ready), 32'd0);
        @(negedge clk);
        check("tx_en_second_cycle", 32'(tx_en[0]), 32'd1);
        check("s_ready_idle2", 32'(s_ready), 32'd0);
        mon_on = 1'b1;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;

        // three-byte packet with tx_ce every other cycle
        ce_alt = 1'b1;
        pkt.delete();
        pkt.push_back(8'h11); pkt.push_back(8'h22); pkt.push_back(8'h33);
        push(8'hFB, 1'b1, 1'b0, 1'b1);
        push_pkt_bytes();
`ifdef TX_LINK_FRAMER_CRC_EN
        c = crc_ref(0, 3);
        push(c[15:8], 1'b0, 1'b0, 1'b0);
        push(c[7:0], 1'b0, 1'b0, 1'b0);
`endif
        push(8'hFD, 1'b1, 1'b0, 1'b0);
        send(0, -1, 0, 1'b1);
        drain("drain_short_pkt");
        ce_alt = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // underrun: two empty slots after the second byte
        pkt.delete();
        for (int i = 0; i < 4; i++) pkt.push_back(8'hA1 + 8'(i));
        push(8'hFB, 1'b1, 1'b0, 1'b1);
        push(8'hA1, 1'b0, 1'b0, 1'b0);
        push(8'hA2, 1'b0, 1'b0, 1'b0);
        push(8'hF7, 1'b1, 1'b0, 1'b0);
        push(8'hF7, 1'b1, 1'b0, 1'b0);
        push(8'hA3, 1'b0, 1'b0, 1'b0);
        push(8'hA4, 1'b0, 1'b0, 1'b0);
`ifdef TX_LINK_FRAMER_CRC_EN
        c = crc_ref(0, 4);
        push(c[15:8], 1'b0, 1'b0, 1'b0);
        push(c[7:0], 1'b0, 1'b0, 1'b0);
`endif
        push(8'hFD, 1'b1, 1'b0, 1'b0);
        send(0, 1, 2, 1'b1);
        drain("drain_underrun");

`ifdef TX_LINK_FRAMER_CRC_EN
        // check value of CRC-16/CCITT-FALSE over "123456789" is 0x29B1
        pkt.delete();
        for (int i = 0; i < 9; i++) pkt.push_back(8'h31 + 8'(i));
        push(8'hFB, 1'b1, 1'b0, 1'b1);
        push_pkt_bytes();
        push(8'h29, 1'b0, 1'b0, 1'b0);
        push(8'hB1, 1'b0, 1'b0, 1'b0);
        push(8'hFD, 1'b1, 1'b0, 1'b0);
        send(0, -1, 0, 1'b1);
        drain("drain_crc_check");
`endif

        // comma re-insertion, COMMA_INTERVAL=4
        sel = 1;
        pkt.delete();
        for (int i = 0; i < 10; i++) pkt.push_back(8'h01 + 8'(i));
        push(8'hFB, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            push(pkt[i], 1'b0, 1'b0, 1'b0);
            if (i == 1 || i == 4 || i == 7) push(8'hBC, 1'b1, 1'b0, 1'b0);
        end
`ifdef TX_LINK_FRAMER_CRC_EN
        c = crc_ref(0, 10);
        push(c[15:8], 1'b0, 1'b0, 1'b0);
        push(8'hBC, 1'b1, 1'b0, 1'b0);
        push(c[7:0], 1'b0, 1'b0, 1'b0);
`endif
        push(8'hFD, 1'b1, 1'b0, 1'b0);
        send(1, -1, 0, 1'b1);
        drain("drain_comma");

        // oversize abort, MAX_PAYLOAD=4, then remainder as a new packet
        sel = 2;
        pkt.delete();
        for (int i = 0; i < 6; i++) pkt.push_back(8'hB1 + 8'(i));
        push(8'hFB, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) push(pkt[i], 1'b0, 1'b0, 1'b0);
        push(8'hFE, 1'b1, 1'b1, 1'b0);
        push(8'hFD, 1'b1, 1'b0, 1'b0);
        push(8'hBC, 1'b1, 1'b0, 1'b0);
        push(8'hBC, 1'b1, 1'b0, 1'b0);
        push(8'hFB, 1'b1, 1'b0, 1'b0);
        push(8'hB5, 1'b0, 1'b0, 1'b0);
        push(8'hB6, 1'b0, 1'b0, 1'b0);
`ifdef TX_LINK_FRAMER_CRC_EN
        c = crc_ref(4, 2);
        push(c[15:8], 1'b0, 1'b0, 1'b0);
        push(c[7:0], 1'b0, 1'b0, 1'b0);
`endif
        push(8'hFD, 1'b1, 1'b0, 1'b0);
        send(2, -1, 0, 1'b1);
        drain("drain_oversize");

        mon_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
